mbist_response_analyzer: RTL and testbench

Downstream checker for the March-style MBIST address/data generator on the 256x4 SRAM. It watches the generator's command stream (address, expected data, write-enable, enable, done) together with the SRAM read port. It compares every read against the expected value after the SRAM read latency, then accumulates the result: a fail count, per-bit fail flags, a first-failure capture and a small failure log drained by a pop handshake. A final pass/fail verdict is raised once the generator finishes and in-flight reads retire.

---
 rtl/mbist_response_analyzer.sv | 224 ++++++++++++++++++++++
 tb/tb_mbist_response_analyzer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_response_analyzer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mbist_response_analyzer                                       |
// | Purpose  : Checks MBIST read responses against expected data; collects a |
// |            fail count, sticky fail bits, first failure and a failure log.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mbist_response_analyzer #(
   parameter int AW        = 8,
   parameter int DW        = 4,
   parameter int RD_LAT    = 1,
   parameter int LOG_DEPTH = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bist_cen,
   input  logic             bist_we,
   input  logic [AW-1:0]    bist_addr,
   input  logic [DW-1:0]    bist_data,
   input  logic             bist_done,
   input  logic [DW-1:0]    mem_dout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [DW-1:0]    fail_bits,
   output logic             ff_vld,
   output logic [AW-1:0]    ff_addr,
   output logic [DW-1:0]    ff_syn,
   output logic             log_vld,
   output logic [AW-1:0]    log_addr,
   output logic [DW-1:0]    log_syn,
   input  logic             log_pop,
   output logic             log_ovf
);

   localparam logic [1:0]       c_idle       = 2'd0;
   localparam logic [1:0]       c_run        = 2'd1;
   localparam logic [1:0]       c_drain      = 2'd2;
   localparam logic [1:0]       c_done       = 2'd3;
   localparam int               c_lpw        = $clog2(LOG_DEPTH);
   localparam logic [c_lpw:0]   c_log_full   = (c_lpw + 1)'(LOG_DEPTH);
   localparam logic [2:0]       c_drain_last = 3'(RD_LAT);
   localparam logic [CNT_W-1:0] c_cnt_max    = '1;

   logic [1:0]                 state_q, state_d;
   logic [2:0]                 drain_cnt_q, drain_cnt_d;
   logic [RD_LAT-1:0]          pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0][AW-1:0]  pipe_addr_q, pipe_addr_d;
   logic [RD_LAT-1:0][DW-1:0]  pipe_exp_q, pipe_exp_d;
   logic [CNT_W-1:0]           fail_cnt_q, fail_cnt_d;
   logic [DW-1:0]              fail_bits_q, fail_bits_d;
   logic                       ff_vld_q, ff_vld_d;
   logic [AW-1:0]              ff_addr_q, ff_addr_d;
   logic [DW-1:0]              ff_syn_q, ff_syn_d;
   logic [LOG_DEPTH-1:0][AW-1:0] log_addr_mem_q, log_addr_mem_d;
   logic [LOG_DEPTH-1:0][DW-1:0] log_syn_mem_q, log_syn_mem_d;
   logic [c_lpw-1:0]           wr_ptr_q, wr_ptr_d;
   logic [c_lpw-1:0]           rd_ptr_q, rd_ptr_d;
   logic [c_lpw:0]             log_cnt_q, log_cnt_d;
   logic                       log_ovf_q, log_ovf_d;

   logic          w_accept;
   logic [DW-1:0] w_syn;
   logic          w_mismatch;
   logic          w_log_full;
   logic          w_pop;
   logic          w_wr;

   // start has priority everywhere: it discards the op and compare of its own cycle
   assign w_accept   = (state_q == c_run) && bist_cen && !bist_we && !bist_done && !start;
   assign w_syn      = pipe_exp_q[RD_LAT-1] ^ mem_dout;
   assign w_mismatch = pipe_vld_q[RD_LAT-1] && (|w_syn) && !start;
   assign w_log_full = (log_cnt_q == c_log_full);
   assign w_pop      = log_pop && (log_cnt_q != '0) && !start;
   assign w_wr       = w_mismatch && (!w_log_full || w_pop);

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         c_idle: if (start) state_d = c_run;
         c_run: begin
            if (start) begin
               state_d = c_run;
            end else if (bist_done) begin
               state_d     = c_drain;
               drain_cnt_d = 3'd0;
            end
         end
         c_drain: begin
            if (start) begin
               state_d = c_run;
            end else if (drain_cnt_q == c_drain_last) begin
               state_d = c_done;
            end else begin
               drain_cnt_d = drain_cnt_q + 3'd1;
            end
         end
         c_done: if (start) state_d = c_run;
         default: state_d = c_idle;
      endcase
   end

   always_comb begin
      pipe_vld_d     = '0;
      pipe_addr_d    = pipe_addr_q;
      pipe_exp_d     = pipe_exp_q;
      pipe_vld_d[0]  = w_accept;
      pipe_addr_d[0] = bist_addr;
      pipe_exp_d[0]  = bist_data;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1] && !start;
         pipe_addr_d[i] = pipe_addr_q[i-1];
         pipe_exp_d[i]  = pipe_exp_q[i-1];
      end
   end

   always_comb begin
      fail_cnt_d  = fail_cnt_q;
      fail_bits_d = fail_bits_q;
      ff_vld_d    = ff_vld_q;
      ff_addr_d   = ff_addr_q;
      ff_syn_d    = ff_syn_q;
      if (start) begin
         fail_cnt_d  = '0;
         fail_bits_d = '0;
         ff_vld_d    = 1'b0;
         ff_addr_d   = '0;
         ff_syn_d    = '0;
      end else if (w_mismatch) begin
         if (fail_cnt_q != c_cnt_max) fail_cnt_d = fail_cnt_q + 1'b1;
         fail_bits_d = fail_bits_q | w_syn;
         if (!ff_vld_q) begin
            ff_vld_d  = 1'b1;
            ff_addr_d = pipe_addr_q[RD_LAT-1];
            ff_syn_d  = w_syn;
         end
      end
   end

   // A push into a full log survives only when a pop frees the head in the same cycle
   always_comb begin
      log_addr_mem_d = log_addr_mem_q;
      log_syn_mem_d  = log_syn_mem_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      log_cnt_d      = log_cnt_q;
      log_ovf_d      = log_ovf_q;
      if (w_wr) begin
         log_addr_mem_d[wr_ptr_q] = pipe_addr_q[RD_LAT-1];
         log_syn_mem_d[wr_ptr_q]  = w_syn;
      end
      if (start) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         log_cnt_d = '0;
         log_ovf_d = 1'b0;
      end else begin
         if (w_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
         if (w_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (w_wr && !w_pop)      log_cnt_d = log_cnt_q + 1'b1;
         else if (!w_wr && w_pop) log_cnt_d = log_cnt_q - 1'b1;
         if (w_mismatch && !w_wr) log_ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= c_idle;
         drain_cnt_q <= 3'd0;
         pipe_vld_q  <= '0;
         pipe_addr_q <= '0;
         pipe_exp_q  <= '0;
         fail_cnt_q  <= '0;
         fail_bits_q <= '0;
         ff_vld_q    <= 1'b0;
         ff_addr_q   <= '0;
         ff_syn_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         log_cnt_q   <= '0;
         log_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_addr_q <= pipe_addr_d;
         pipe_exp_q  <= pipe_exp_d;
         fail_cnt_q  <= fail_cnt_d;
         fail_bits_q <= fail_bits_d;
         ff_vld_q    <= ff_vld_d;
         ff_addr_q   <= ff_addr_d;
         ff_syn_q    <= ff_syn_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         log_cnt_q   <= log_cnt_d;
         log_ovf_q   <= log_ovf_d;
      end
   end

   // Log storage needs no reset: entries are only visible through a non-zero count
   always_ff @(posedge clk) begin
      log_addr_mem_q <= log_addr_mem_d;
      log_syn_mem_q  <= log_syn_mem_d;
   end

   assign busy      = (state_q == c_run) || (state_q == c_drain);
   assign done      = (state_q == c_done);
   assign pass      = (state_q == c_done) && (fail_cnt_q == '0);
   assign fail_cnt  = fail_cnt_q;
   assign fail_bits = fail_bits_q;
   assign ff_vld    = ff_vld_q;
   assign ff_addr   = ff_addr_q;
   assign ff_syn    = ff_syn_q;
   assign log_vld   = (log_cnt_q != '0);
   assign log_addr  = log_vld ? log_addr_mem_q[rd_ptr_q] : '0;
   assign log_syn   = log_vld ? log_syn_mem_q[rd_ptr_q] : '0;
   assign log_ovf   = log_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mbist_response_analyzer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mbist_response_analyzer                                    |
// | Purpose  : Directed bench for the analyzer at read latencies 1 and 3,    |
// |            driven by a March C- stream against a small SRAM model.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mbist_response_analyzer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, bist_cen, bist_we, bist_done, log_pop;
   logic [7:0] bist_addr;
   logic [3:0] bist_data;
   logic [3:0] mem_dout1, mem_dout3;

   logic       busy_1, done_1, pass_1, ff_vld_1, log_vld_1, log_ovf_1;
   logic [7:0] fail_cnt_1, ff_addr_1, log_addr_1;
   logic [3:0] fail_bits_1, ff_syn_1, log_syn_1;
   logic       busy_3, done_3, pass_3, ff_vld_3, log_vld_3, log_ovf_3;
   logic [7:0] fail_cnt_3, ff_addr_3, log_addr_3;
   logic [3:0] fail_bits_3, ff_syn_3, log_syn_3;

   int tests_run    = 0;
   int tests_failed = 0;

   mbist_response_analyzer #(.AW(8), .DW(4), .RD_LAT(1), .LOG_DEPTH(4), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .bist_cen(bist_cen), .bist_we(bist_we),
      .bist_addr(bist_addr), .bist_data(bist_data), .bist_done(bist_done), .mem_dout(mem_dout1),
      .busy(busy_1), .done(done_1), .pass(pass_1), .fail_cnt(fail_cnt_1), .fail_bits(fail_bits_1),
      .ff_vld(ff_vld_1), .ff_addr(ff_addr_1), .ff_syn(ff_syn_1), .log_vld(log_vld_1),
      .log_addr(log_addr_1), .log_syn(log_syn_1), .log_pop(log_pop), .log_ovf(log_ovf_1));

   mbist_response_analyzer #(.AW(8), .DW(4), .RD_LAT(3), .LOG_DEPTH(4), .CNT_W(8)) u_dut3 (
      .clk(clk), .rst(rst), .start(start), .bist_cen(bist_cen), .bist_we(bist_we),
      .bist_addr(bist_addr), .bist_data(bist_data), .bist_done(bist_done), .mem_dout(mem_dout3),
      .busy(busy_3), .done(done_3), .pass(pass_3), .fail_cnt(fail_cnt_3), .fail_bits(fail_bits_3),
      .ff_vld(ff_vld_3), .ff_addr(ff_addr_3), .ff_syn(ff_syn_3), .log_vld(log_vld_3),
      .log_addr(log_addr_3), .log_syn(log_syn_3), .log_pop(log_pop), .log_ovf(log_ovf_3));

   // SRAM model: stuck-at-1 masks applied on read, 1- and 3-cycle read ports
   logic [3:0] sram [256];
   logic [3:0] sa1  [256];
   logic [3:0] rd1, rd2, rd3;
   always @(posedge clk) begin
      if (bist_cen && bist_we) sram[bist_addr] <= bist_data;
      rd1 <= sram[bist_addr] | sa1[bist_addr];
      rd2 <= rd1;
      rd3 <= rd2;
   end
   assign mem_dout1 = rd1;
   assign mem_dout3 = rd3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic cen, input logic we, input logic [7:0] a, input logic [3:0] d);
      bist_cen  = cen;
      bist_we   = we;
      bist_addr = a;
      bist_data = d;
      tick();
   endtask

   task automatic pulse_start();
      bist_done = 1'b0;
      bist_cen  = 1'b0;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic pop_once();
      log_pop = 1'b1;
      tick();
      log_pop = 1'b0;
   endtask

   task automatic march_elem(input bit down, input bit do_r, input logic [3:0] rv,
                             input bit do_w, input logic [3:0] wv);
      for (int k = 0; k < 256; k++) begin
         logic [7:0] a;
         a = down ? 8'(255 - k) : 8'(k);
         if (do_r) op(1'b1, 1'b0, a, rv);
         if (do_w) op(1'b1, 1'b1, a, wv);
      end
   endtask

   task automatic run_march();
      march_elem(1'b0, 1'b0, 4'h0, 1'b1, 4'h0);
      march_elem(1'b0, 1'b1, 4'h0, 1'b1, 4'hF);
      march_elem(1'b0, 1'b1, 4'hF, 1'b1, 4'h0);
      march_elem(1'b1, 1'b1, 4'h0, 1'b1, 4'hF);
      march_elem(1'b1, 1'b1, 4'hF, 1'b1, 4'h0);
      march_elem(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
      op(1'b0, 1'b0, 8'h00, 4'h0);
   endtask

   task automatic finish_run();
      int n;
      bist_cen  = 1'b0;
      bist_done = 1'b1;
      n = 0;
      while (!done_1 && n < 40) begin
         tick();
         n++;
      end
      tests_run++; if (done_1 !== 1'b1) begin tests_failed++; $display("FAIL done_timeout: got done=%b expected 1 within 40 cycles", done_1); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      tests_run++; if ({busy_1, done_1, pass_1, ff_vld_1, log_vld_1, log_ovf_1} !== 6'b0) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000000", {busy_1, done_1, pass_1, ff_vld_1, log_vld_1, log_ovf_1}); end
      tests_run++; if (fail_cnt_1 !== 8'd0) begin tests_failed++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt_1); end
      tests_run++; if ({fail_bits_1, ff_syn_1, log_syn_1, ff_addr_1, log_addr_1} !== 28'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {fail_bits_1, ff_syn_1, log_syn_1, ff_addr_1, log_addr_1}); end
      tests_run++; if ({busy_3, done_3, fail_cnt_3} !== 10'h0) begin tests_failed++; $display("FAIL reset_dut3: got %h expected 0", {busy_3, done_3, fail_cnt_3}); end
   endtask

   task automatic test_clean_march();
      pulse_start();
      tests_run++; if (busy_1 !== 1'b1) begin tests_failed++; $display("FAIL clean_busy: got %b expected 1", busy_1); end
      tests_run++; if (pass_1 !== 1'b0) begin tests_failed++; $display("FAIL clean_pass_early: got %b expected 0", pass_1); end
      run_march();
      finish_run();
      tests_run++; if (pass_1 !== 1'b1) begin tests_failed++; $display("FAIL clean_pass: got %b expected 1", pass_1); end
      tests_run++; if (busy_1 !== 1'b0) begin tests_failed++; $display("FAIL clean_busy_end: got %b expected 0", busy_1); end
      tests_run++; if ({fail_cnt_1, fail_bits_1} !== 12'h0) begin tests_failed++; $display("FAIL clean_counts: got %h expected 0", {fail_cnt_1, fail_bits_1}); end
      tests_run++; if ({log_vld_1, ff_vld_1, log_ovf_1} !== 3'b0) begin tests_failed++; $display("FAIL clean_flags: got %b expected 000", {log_vld_1, ff_vld_1, log_ovf_1}); end
   endtask

   task automatic test_stuck_at();
      sa1[8'h3C] = 4'b0100;
      pulse_start();
      run_march();
      finish_run();
      sa1[8'h3C] = 4'b0000;
      tests_run++; if ({ff_vld_1, ff_addr_1, ff_syn_1} !== {1'b1, 8'h3C, 4'b0100}) begin tests_failed++; $display("FAIL sa_first_fail: got vld=%b addr=%h syn=%b expected 1/3c/0100", ff_vld_1, ff_addr_1, ff_syn_1); end
      tests_run++; if (fail_bits_1 !== 4'b0100) begin tests_failed++; $display("FAIL sa_fail_bits: got %b expected 0100", fail_bits_1); end
      tests_run++; if (fail_cnt_1 !== 8'd3) begin tests_failed++; $display("FAIL sa_fail_cnt: got %0d expected 3", fail_cnt_1); end
      tests_run++; if (pass_1 !== 1'b0) begin tests_failed++; $display("FAIL sa_pass: got %b expected 0", pass_1); end
      tests_run++; if ({log_vld_1, log_addr_1, log_syn_1, log_ovf_1} !== {1'b1, 8'h3C, 4'b0100, 1'b0}) begin tests_failed++; $display("FAIL sa_log: got vld=%b addr=%h syn=%b ovf=%b expected 1/3c/0100/0", log_vld_1, log_addr_1, log_syn_1, log_ovf_1); end
   endtask

   task automatic test_log_overflow();
      pulse_start();
      for (int i = 0; i < 6; i++) op(1'b1, 1'b0, 8'(8'hA0 + i), 4'(i + 1));
      repeat (3) op(1'b0, 1'b0, 8'h00, 4'h0);
      tests_run++; if (fail_cnt_1 !== 8'd6) begin tests_failed++; $display("FAIL ovf_fail_cnt: got %0d expected 6", fail_cnt_1); end
      tests_run++; if (log_ovf_1 !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", log_ovf_1); end
      tests_run++; if (fail_bits_1 !== 4'h7) begin tests_failed++; $display("FAIL ovf_fail_bits: got %h expected 7", fail_bits_1); end
      tests_run++; if ({ff_addr_1, ff_syn_1} !== {8'hA0, 4'h1}) begin tests_failed++; $display("FAIL ovf_first_fail: got %h/%h expected a0/1", ff_addr_1, ff_syn_1); end
      for (int k = 0; k < 4; k++) begin
         tests_run++; if ({log_vld_1, log_addr_1, log_syn_1} !== {1'b1, 8'(8'hA0 + k), 4'(k + 1)}) begin tests_failed++; $display("FAIL ovf_log_entry%0d: got vld=%b addr=%h syn=%h expected 1/%h/%h", k, log_vld_1, log_addr_1, log_syn_1, 8'(8'hA0 + k), 4'(k + 1)); end
         pop_once();
      end
      tests_run++; if (log_vld_1 !== 1'b0) begin tests_failed++; $display("FAIL ovf_log_empty: got %b expected 0", log_vld_1); end
      pop_once();
      tests_run++; if ({log_vld_1, log_ovf_1} !== 2'b01) begin tests_failed++; $display("FAIL ovf_pop_empty: got vld=%b ovf=%b expected 0/1", log_vld_1, log_ovf_1); end
   endtask

   task automatic test_push_pop_full();
      pulse_start();
      for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'(8'hB0 + i), 4'(i + 1));
      repeat (2) op(1'b0, 1'b0, 8'h00, 4'h0);
      op(1'b1, 1'b0, 8'hB4, 4'h5);
      // the B4 compare lands in this cycle, together with the pop
      bist_cen = 1'b0;
      pop_once();
      tests_run++; if (log_ovf_1 !== 1'b0) begin tests_failed++; $display("FAIL pp_ovf: got %b expected 0", log_ovf_1); end
      tests_run++; if (fail_cnt_1 !== 8'd5) begin tests_failed++; $display("FAIL pp_fail_cnt: got %0d expected 5", fail_cnt_1); end
      for (int k = 1; k < 5; k++) begin
         tests_run++; if ({log_vld_1, log_addr_1, log_syn_1} !== {1'b1, 8'(8'hB0 + k), 4'(k + 1)}) begin tests_failed++; $display("FAIL pp_log_entry%0d: got vld=%b addr=%h syn=%h expected 1/%h/%h", k, log_vld_1, log_addr_1, log_syn_1, 8'(8'hB0 + k), 4'(k + 1)); end
         pop_once();
      end
      tests_run++; if (log_vld_1 !== 1'b0) begin tests_failed++; $display("FAIL pp_log_empty: got %b expected 0", log_vld_1); end
   endtask

   task automatic test_rdlat3_done();
      sa1[8'h50] = 4'h8;
      pulse_start();
      op(1'b1, 1'b0, 8'h4E, 4'h0);
      op(1'b1, 1'b0, 8'h4F, 4'h0);
      op(1'b1, 1'b0, 8'h50, 4'h0);
      op(1'b0, 1'b0, 8'h00, 4'h0);
      bist_done = 1'b1;
      repeat (4) tick();
      tests_run++; if ({busy_3, done_3} !== 2'b10) begin tests_failed++; $display("FAIL l3_d_plus_4: got busy=%b done=%b expected 1/0", busy_3, done_3); end
      tick();
      tests_run++; if ({busy_3, done_3} !== 2'b01) begin tests_failed++; $display("FAIL l3_d_plus_5: got busy=%b done=%b expected 0/1", busy_3, done_3); end
      tests_run++; if ({fail_cnt_3, ff_addr_3, ff_syn_3, pass_3} !== {8'd1, 8'h50, 4'h8, 1'b0}) begin tests_failed++; $display("FAIL l3_last_read: got cnt=%0d addr=%h syn=%h pass=%b expected 1/50/8/0", fail_cnt_3, ff_addr_3, ff_syn_3, pass_3); end
      sa1[8'h50] = 4'h0;
   endtask

   task automatic test_start_flush();
      pulse_start();
      for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'hC0 + i), 4'hF);
      repeat (2) op(1'b0, 1'b0, 8'h00, 4'h0);
      tests_run++; if ({fail_cnt_1, log_ovf_1} !== {8'd5, 1'b1}) begin tests_failed++; $display("FAIL sf_before: got cnt=%0d ovf=%b expected 5/1", fail_cnt_1, log_ovf_1); end
      op(1'b1, 1'b0, 8'hC5, 4'hF);
      start = 1'b1;
      op(1'b1, 1'b0, 8'hC6, 4'hF);
      start    = 1'b0;
      bist_cen = 1'b0;
      tests_run++; if ({fail_cnt_1, ff_vld_1, log_vld_1, log_ovf_1, busy_1} !== {8'd0, 4'b0001}) begin tests_failed++; $display("FAIL sf_cleared: got cnt=%0d ff=%b log=%b ovf=%b busy=%b expected 0/0/0/0/1", fail_cnt_1, ff_vld_1, log_vld_1, log_ovf_1, busy_1); end
      repeat (5) tick();
      tests_run++; if ({fail_cnt_1, fail_cnt_3} !== 16'h0) begin tests_failed++; $display("FAIL sf_flushed: got cnt1=%0d cnt3=%0d expected 0/0", fail_cnt_1, fail_cnt_3); end
   endtask

   task automatic test_back_to_back_sat();
      pulse_start();
      for (int i = 0; i < 10; i++) op(1'b1, 1'b0, 8'(i), 4'hF);
      repeat (2) op(1'b0, 1'b0, 8'h00, 4'h0);
      tests_run++; if (fail_cnt_1 !== 8'd10) begin tests_failed++; $display("FAIL b2b_fail_cnt: got %0d expected 10", fail_cnt_1); end
      for (int i = 0; i < 250; i++) op(1'b1, 1'b0, 8'(i), 4'hF);
      repeat (4) op(1'b0, 1'b0, 8'h00, 4'h0);
      tests_run++; if ({fail_cnt_1, fail_bits_1} !== {8'd255, 4'hF}) begin tests_failed++; $display("FAIL sat_cnt1: got cnt=%0d bits=%h expected 255/f", fail_cnt_1, fail_bits_1); end
      tests_run++; if (fail_cnt_3 !== 8'd255) begin tests_failed++; $display("FAIL sat_cnt3: got %0d expected 255", fail_cnt_3); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      for (int i = 0; i < 256; i++) sa1[i] = 4'h0;
      rst = 1'b1; start = 1'b0; bist_cen = 1'b0; bist_we = 1'b0; bist_done = 1'b0;
      log_pop = 1'b0; bist_addr = 8'h00; bist_data = 4'h0;
      test_reset();
      test_clean_march();
      test_stuck_at();
      test_log_overflow();
      test_push_pop_full();
      test_rdlat3_done();
      test_start_flush();
      test_back_to_back_sat();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
